// File: rtl/sev_seg_pkg.sv
// Shared constants and helpers for seven-segment display blocks.
// Segment patterns are active-high {dp,g,f,e,d,c,b,a}.
package sev_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [7:0] applyPolarity(input logic [7:0] pattern, input logic activeLow);
    return activeLow ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/sev_seg_decoder.sv
// Combinational nibble + dp + blank to active-high segment pattern.
module sev_seg_decoder (
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_pattern
);
  import sev_seg_pkg::*;

  // Blanking removes only a..g; the decimal point is independent.
  always_comb begin
    o_pattern = '0;
    if (!i_blank) o_pattern[SEG_G:SEG_A] = HEX_SEG[i_nibble];
    o_pattern[SEG_DP] = i_dp;
  end

endmodule

// File: rtl/sev_seg_scan_display.sv
// Multiplexed seven-segment scan driver with double-buffered loads,
// leading-zero suppression, per-slot dead time and PWM brightness.
module sev_seg_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int DEAD_CYC   = 4,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    BrdClk,
  input  logic                    aReset_n,
  input  logic                    bLoad,
  input  logic [4*NUM_DIGITS-1:0] bValue,
  input  logic [NUM_DIGITS-1:0]   bDpMask,
  input  logic                    bLzSuppress,
  input  logic [BRIGHT_W-1:0]     bBrightness,
  output logic                    bPending,
  output logic                    bLoadAck,
  output logic                    bFrameDone,
  output logic [NUM_DIGITS-1:0]   bDigitSel,
  output logic [7:0]              bSegmentOutput
);
  import sev_seg_pkg::*;

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] DEAD_V     = PW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic          POL_LOW    = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = POL_LOW ? '1 : '0;
  localparam logic [7:0]    SEG_OFF    = applyPolarity(8'h00, POL_LOW);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [BRIGHT_W-1:0]     r_pwm;
  logic [4*NUM_DIGITS-1:0] r_dispVal;
  logic [NUM_DIGITS-1:0]   r_dispDp;
  logic [4*NUM_DIGITS-1:0] r_pendVal;
  logic [NUM_DIGITS-1:0]   r_pendDp;
  logic                    r_pending;
  logic                    r_loadAck;
  logic                    r_frameDone;
  logic [NUM_DIGITS-1:0]   r_digitSel;
  logic [7:0]              r_seg;

  logic                    w_tick;
  logic                    w_boundary;
  logic [3:0]              w_nibble;
  logic                    w_dp;
  logic [IW-1:0]           w_msIdx;
  logic [NUM_DIGITS-1:0]   w_selOneHot;
  logic                    w_blank;
  logic                    w_pwmOn;
  logic                    w_enable;
  logic [7:0]              w_pattern;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  always_ff @(posedge BrdClk or negedge aReset_n) begin
    if (!aReset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_pwm   <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // A load on the boundary cycle still sees the old pending copied to display.
  always_ff @(posedge BrdClk or negedge aReset_n) begin
    if (!aReset_n) begin
      r_dispVal   <= '0;
      r_dispDp    <= '0;
      r_pendVal   <= '0;
      r_pendDp    <= '0;
      r_pending   <= 1'b0;
      r_loadAck   <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_boundary;
      r_loadAck   <= w_boundary && r_pending;
      if (w_boundary && r_pending) begin
        r_dispVal <= r_pendVal;
        r_dispDp  <= r_pendDp;
      end
      if (bLoad) begin
        r_pendVal <= bValue;
        r_pendDp  <= bDpMask;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_nibble    = '0;
    w_dp        = 1'b0;
    w_msIdx     = '0;
    w_selOneHot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_selOneHot[i] = (r_idx == IW'(i));
      if (r_idx == IW'(i)) begin
        w_nibble = r_dispVal[4*i +: 4];
        w_dp     = r_dispDp[i];
      end
      if (r_dispVal[4*i +: 4] != 4'h0) w_msIdx = IW'(i);
    end
  end

  assign w_blank  = bLzSuppress && (r_idx > w_msIdx);
  assign w_pwmOn  = (&bBrightness) || (r_pwm < bBrightness);
  assign w_enable = (r_presc >= DEAD_V) && w_pwmOn;

  sev_seg_decoder u_decoder (
    .i_nibble (w_nibble),
    .i_dp     (w_dp),
    .i_blank  (w_blank),
    .o_pattern(w_pattern)
  );

  always_ff @(posedge BrdClk or negedge aReset_n) begin
    if (!aReset_n) begin
      r_digitSel <= SEL_OFF;
      r_seg      <= SEG_OFF;
    end else if (w_enable) begin
      r_digitSel <= POL_LOW ? ~w_selOneHot : w_selOneHot;
      r_seg      <= applyPolarity(w_pattern, POL_LOW);
    end else begin
      r_digitSel <= SEL_OFF;
      r_seg      <= SEG_OFF;
    end
  end

  assign bPending       = r_pending;
  assign bLoadAck       = r_loadAck;
  assign bFrameDone     = r_frameDone;
  assign bDigitSel      = r_digitSel;
  assign bSegmentOutput = r_seg;

endmodule

// File: tb/tb_sev_seg_scan_display.sv
// Bench for sev_seg_scan_display: directed steps plus random loads against
// a cycle-count based reference model (4 digits, DIV=10, dead=2, 2-bit PWM).
module tb_sev_seg_scan_display;

  logic        BrdClk = 1'b0;
  logic        aReset_n;
  logic        bLoad;
  logic [15:0] bValue;
  logic [3:0]  bDpMask;
  logic        bLzSuppress;
  logic [1:0]  bBrightness;
  logic        bPending;
  logic        bLoadAck;
  logic        bFrameDone;
  logic [3:0]  bDigitSel;
  logic [7:0]  bSegmentOutput;

  int tests  = 0;
  int failed = 0;

  // reference model state
  int          mT;
  logic [15:0] mDispVal, mPendVal;
  logic [3:0]  mDispDp, mPendDp;
  bit          mPendFlag;
  logic [3:0]  eSel;
  logic [7:0]  eSeg;
  bit          eAck, eFrame;

  logic [6:0]  segTab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          ackCount;
  int          enCount;
  logic [7:0]  capSeg [4];

  sev_seg_scan_display #(
    .NUM_DIGITS(4), .CLK_HZ(1000), .REFRESH_HZ(100),
    .DEAD_CYC(2), .BRIGHT_W(2), .ACTIVE_LOW(1)
  ) dut (
    .BrdClk        (BrdClk),
    .aReset_n      (aReset_n),
    .bLoad         (bLoad),
    .bValue        (bValue),
    .bDpMask       (bDpMask),
    .bLzSuppress   (bLzSuppress),
    .bBrightness   (bBrightness),
    .bPending      (bPending),
    .bLoadAck      (bLoadAck),
    .bFrameDone    (bFrameDone),
    .bDigitSel     (bDigitSel),
    .bSegmentOutput(bSegmentOutput)
  );

  always #5 BrdClk = ~BrdClk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mT = 0; mDispVal = '0; mDispDp = '0; mPendVal = '0; mPendDp = '0; mPendFlag = 0;
  endtask

  // Slot position, digit and PWM phase all follow from the cycle count since reset.
  task automatic modelStep(input bit ld);
    int presc, idx, pwm, msd;
    logic [3:0] nib;
    logic [7:0] hi;
    presc = mT % 10;
    idx   = (mT / 10) % 4;
    pwm   = mT % 4;
    eSel  = 4'hF;
    eSeg  = 8'hFF;
    if (presc >= 2 && (bBrightness == 2'd3 || pwm < int'(bBrightness))) begin
      eSel[idx] = 1'b0;
      msd = 0;
      for (int k = 0; k < 4; k++)
        if (((mDispVal >> (4*k)) & 16'hF) != 16'h0) msd = k;
      nib = 4'((mDispVal >> (4*idx)) & 16'hF);
      hi  = (bLzSuppress && idx > msd) ? 8'h00 : {1'b0, segTab[nib]};
      hi[7] = mDispDp[idx];
      eSeg = ~hi;
    end
    eFrame = (presc == 9 && idx == 3);
    eAck   = eFrame && mPendFlag;
    if (eAck) begin mDispVal = mPendVal; mDispDp = mPendDp; end
    if (ld) begin mPendVal = bValue; mPendDp = bDpMask; mPendFlag = 1; end
    else if (eFrame) mPendFlag = 0;
    mT++;
  endtask

  task automatic applyStimulus(input bit ld);
    bLoad = ld;
    @(posedge BrdClk);
    modelStep(ld);
    #1;
    bLoad = 1'b0;
    checkOutput("digit_sel",   bDigitSel,      eSel);
    checkOutput("segments",    bSegmentOutput, eSeg);
    checkOutput("pending",     bPending,       mPendFlag);
    checkOutput("load_ack",    bLoadAck,       eAck);
    checkOutput("frame_done",  bFrameDone,     eFrame);
    if (bLoadAck) ackCount++;
    if (bDigitSel != 4'hF) begin
      enCount++;
      for (int i = 0; i < 4; i++) if (!bDigitSel[i]) capSeg[i] = bSegmentOutput;
    end
  endtask

  task automatic runUntilAck(input int budget);
    int n = 0;
    do begin
      applyStimulus(0);
      n++;
    end while (!bLoadAck && n < budget);
    checkOutput("ack_within_budget", bLoadAck, 1);
  endtask

  task automatic captureFrame();
    for (int i = 0; i < 4; i++) capSeg[i] = 8'h00;
    for (int i = 0; i < 40; i++) applyStimulus(0);
  endtask

  task automatic checkDigits(input string tag, input logic [31:0] expPacked);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s_d%0d", tag, i), capSeg[i], expPacked[8*i +: 8]);
  endtask

  initial begin
    bit ld;
    aReset_n = 1'b0; bLoad = 1'b0; bValue = '0; bDpMask = '0;
    bLzSuppress = 1'b0; bBrightness = 2'd3;
    ackCount = 0; enCount = 0;
    modelReset();

    // reset state
    repeat (3) @(posedge BrdClk);
    #1;
    checkOutput("rst_sel",     bDigitSel,      4'hF);
    checkOutput("rst_seg",     bSegmentOutput, 8'hFF);
    checkOutput("rst_pending", bPending,       0);
    checkOutput("rst_ack",     bLoadAck,       0);
    checkOutput("rst_frame",   bFrameDone,     0);
    @(negedge BrdClk);
    aReset_n = 1'b1;

    // dead time then first enable on digit 0
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("dead_slot0", bDigitSel, 4'hF);
    applyStimulus(0);
    checkOutput("first_enable", bDigitSel, 4'hE);

    // load 12AF
    bValue = 16'h12AF; bDpMask = 4'b0000;
    applyStimulus(1);
    checkOutput("pending_rises", bPending, 1);
    runUntilAck(60);
    checkOutput("ack_with_frame", bFrameDone, 1);
    captureFrame();
    checkDigits("load12AF", 32'hF9A4_888E);

    // overwrite within one frame
    ackCount = 0;
    bValue = 16'h1111;
    applyStimulus(1);
    repeat (5) applyStimulus(0);
    bValue = 16'h2222;
    applyStimulus(1);
    runUntilAck(60);
    captureFrame();
    checkDigits("overwrite", 32'hA4A4_A4A4);
    checkOutput("overwrite_ack_count", ackCount, 1);

    // leading-zero suppression
    bLzSuppress = 1'b1; bValue = 16'h0050; bDpMask = 4'b1000;
    applyStimulus(1);
    runUntilAck(60);
    captureFrame();
    checkDigits("lzs", 32'h7FFF_92C0);

    // brightness
    bBrightness = 2'd0;
    applyStimulus(0);
    enCount = 0;
    repeat (40) applyStimulus(0);
    checkOutput("bright0_enables", enCount, 0);
    bBrightness = 2'd1;
    applyStimulus(0);
    enCount = 0;
    repeat (40) applyStimulus(0);
    checkOutput("bright1_enables", enCount, 8);
    bBrightness = 2'd3;

    // load landing on the boundary cycle
    bLzSuppress = 1'b0; bDpMask = 4'b0000;
    bValue = 16'h3456;
    applyStimulus(1);
    for (int k = 0; k < 50 && (mT % 40) != 39; k++) applyStimulus(0);
    bValue = 16'h789A;
    applyStimulus(1);
    checkOutput("boundary_ack", bLoadAck, 1);
    checkOutput("boundary_pending_kept", bPending, 1);
    for (int k = 0; k < 50 && (mT % 40) != 39; k++) applyStimulus(0);
    applyStimulus(0);
    checkOutput("boundary_second_ack", bLoadAck, 1);
    checkOutput("boundary_pending_clear", bPending, 0);
    captureFrame();
    checkDigits("boundary", 32'hF880_9088);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      ld = 0;
      if ($urandom_range(0, 7) == 0) begin
        bValue  = 16'($urandom) >> (4 * $urandom_range(0, 3));
        bDpMask = 4'($urandom);
        ld = 1;
      end
      if ($urandom_range(0, 31) == 0) bLzSuppress = ~bLzSuppress;
      if ($urandom_range(0, 31) == 0) bBrightness = 2'($urandom);
      applyStimulus(ld);
    end

    // asynchronous reset mid-frame drops the pending load
    bValue = 16'hBEEF; bDpMask = 4'b0101;
    applyStimulus(1);
    repeat (3) applyStimulus(0);
    #2;
    aReset_n = 1'b0;
    #1;
    checkOutput("midrst_sel",     bDigitSel,      4'hF);
    checkOutput("midrst_seg",     bSegmentOutput, 8'hFF);
    checkOutput("midrst_pending", bPending,       0);
    checkOutput("midrst_ack",     bLoadAck,       0);
    bLzSuppress = 1'b0; bBrightness = 2'd3;
    repeat (2) @(posedge BrdClk);
    @(negedge BrdClk);
    aReset_n = 1'b1;
    modelReset();
    ackCount = 0;
    repeat (45) applyStimulus(0);
    checkOutput("midrst_no_ack", ackCount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
